// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master between two requesters.
// Latches the winner's length/TX word, pulses ENABLE, waits for DONE or timeout, then acks.
module spi_master_arbiter #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int MAX_LEN        = DATA_WIDTH/8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req0_i,
   input  logic                  req1_i,
   input  logic [7:0]            len0_i,
   input  logic [7:0]            len1_i,
   input  logic [DATA_WIDTH-1:0] tx0_i,
   input  logic [DATA_WIDTH-1:0] tx1_i,
   output logic                  ack0_o,
   output logic                  ack1_o,
   output logic [DATA_WIDTH-1:0] rx0_o,
   output logic [DATA_WIDTH-1:0] rx1_o,
   output logic                  err0_o,
   output logic                  err1_o,
   output logic [1:0]            grant_o,
   output logic                  busy_o,
   output logic                  spi_enable_o,
   output logic [7:0]            spi_length_o,
   output logic [DATA_WIDTH-1:0] spi_data_in_o,
   input  logic [DATA_WIDTH-1:0] spi_data_out_i,
   input  logic                  spi_done_i
);

   localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic [1:0]            grant_q, grant_d;
   logic [7:0]            len_q, len_d;
   logic [DATA_WIDTH-1:0] txd_q, txd_d;
   logic [DATA_WIDTH-1:0] rx0_q, rx0_d;
   logic [DATA_WIDTH-1:0] rx1_q, rx1_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  win;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;   // so requester 0 wins the first tie
         grant_q <= '0;
         len_q   <= '0;
         txd_q   <= '0;
         rx0_q   <= '0;
         rx1_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         len_q   <= len_d;
         txd_q   <= txd_d;
         rx0_q   <= rx0_d;
         rx1_q   <= rx1_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      grant_d = grant_q;
      len_d   = len_q;
      txd_d   = txd_q;
      rx0_d   = rx0_q;
      rx1_d   = rx1_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      win     = 1'b0;
      // cnt_inc is the number of cycles elapsed since the ENABLE cycle
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (req0_i || req1_i) begin
               win     = (req0_i && req1_i) ? ~last_q : req1_i;
               owner_d = win;
               last_d  = win;
               grant_d = win ? 2'b10 : 2'b01;
               len_d   = win ? len1_i : len0_i;
               txd_d   = win ? tx1_i : tx0_i;
               if (len_d == 8'd0 || len_d > MAX_LEN_B) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_START;
               end
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (spi_done_i) begin
               err_d   = 1'b0;
               state_d = S_RESP;
               if (owner_q) rx1_d = spi_data_out_i;
               else         rx0_d = spi_data_out_i;
            end else if (cnt_inc == LIMIT) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy_o        = (state_q != S_IDLE);
   assign spi_enable_o  = (state_q == S_START);
   assign ack0_o        = (state_q == S_RESP) && !owner_q;
   assign ack1_o        = (state_q == S_RESP) &&  owner_q;
   assign err0_o        = ack0_o && err_q;
   assign err1_o        = ack1_o && err_q;
   assign grant_o       = grant_q;
   assign spi_length_o  = len_q;
   assign spi_data_in_o = txd_q;
   assign rx0_o         = rx0_q;
   assign rx1_o         = rx1_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed table, reset/contention sequence, randomized transfers.
// The model predicts the winner and each transfer's outcome from request state and DONE delay.
module tb_spi_master_arbiter;

   localparam int DW    = 16;
   localparam int T     = 50;
   localparam int MAXL  = DW/8;
   localparam int NEVER = 1000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [7:0]    len0 = '0, len1 = '0;
   logic [DW-1:0] tx0 = '0, tx1 = '0;
   logic          ack0, ack1, err0, err1, busy, spi_enable;
   logic [DW-1:0] rx0, rx1, spi_data_in;
   logic [1:0]    grant;
   logic [7:0]    spi_length;
   logic [DW-1:0] dout = '0;
   logic          done = 1'b0;

   spi_master_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_i(req0), .req1_i(req1), .len0_i(len0), .len1_i(len1),
      .tx0_i(tx0), .tx1_i(tx1),
      .ack0_o(ack0), .ack1_o(ack1), .rx0_o(rx0), .rx1_o(rx1),
      .err0_o(err0), .err1_o(err1), .grant_o(grant), .busy_o(busy),
      .spi_enable_o(spi_enable), .spi_length_o(spi_length),
      .spi_data_in_o(spi_data_in), .spi_data_out_i(dout), .spi_done_i(done)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // requester-side model: pending flags, values seen at grant, expected RX words
   bit            pend [2];
   logic [7:0]    mlen [2];
   logic [DW-1:0] mtx  [2];
   logic [DW-1:0] mrx  [2];
   int            last = 1;

   typedef struct {
      bit r0, r1; logic [7:0] l0, l1; logic [DW-1:0] t0, t1;
      int d; logic [DW-1:0] rd; int w; bit err; bit late;
   } row_t;
   row_t tbl [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic raise(input int i, input logic [7:0] l, input logic [DW-1:0] t);
      pend[i] = 1'b1; mlen[i] = l; mtx[i] = t;
      if (i == 0) begin len0 = l; tx0 = t; end
      else        begin len1 = l; tx1 = t; end
      req0 = pend[0]; req1 = pend[1];
   endtask

   function automatic int predict_winner();
      if (pend[0] && pend[1]) return 1 - last;
      return pend[1] ? 1 : 0;
   endfunction

   // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
   task automatic xfer(input int w, input bit eerr, input int d, input logic [DW-1:0] rd, input bit spur);
      logic [1:0]    g;
      logic [7:0]    l;
      logic [DW-1:0] t;
      bit            illegal;
      g = (w == 1) ? 2'b10 : 2'b01;
      l = mlen[w];
      t = mtx[w];
      illegal = (l == 8'd0) || (int'(l) > MAXL);
      tick();
      check("grant", 64'(grant), 64'(g));
      if (!illegal) begin
         check("start", 64'({spi_enable, busy, ack0, ack1}), 64'(4'b1100));
         check("spi_len", 64'(spi_length), 64'(l));
         check("spi_din", 64'(spi_data_in), 64'(t));
         if (w == 0) begin len0 = 8'($urandom); tx0 = 16'($urandom); end
         else        begin len1 = 8'($urandom); tx1 = 16'($urandom); end
         if (spur) begin done = 1'b1; dout = 16'($urandom); end
         for (int k = 1; k < T; k++) begin
            tick();
            check("wait", 64'({ack0, ack1, err0, err1, spi_enable, busy, grant}), 64'({6'b000001, g}));
            done = (k == d);
            dout = (k == d) ? rd : 16'($urandom);
            if (k == d) break;
         end
         tick();
         done = 1'b0;
      end
      check("ack", 64'({ack0, ack1}), 64'((w == 1) ? 2'b01 : 2'b10));
      check("err", 64'({err0, err1}), 64'(eerr ? ((w == 1) ? 2'b01 : 2'b10) : 2'b00));
      check("resp", 64'({spi_enable, busy, grant}), 64'({2'b01, g}));
      check("resp_len", 64'({spi_length, spi_data_in}), 64'({l, t}));
      if (!eerr) mrx[w] = rd;
      check("rx0", 64'(rx0), 64'(mrx[0]));
      check("rx1", 64'(rx1), 64'(mrx[1]));
      pend[w] = 1'b0;
      req0 = pend[0]; req1 = pend[1];
      last = w;
      if (spur) begin done = 1'b1; dout = 16'($urandom); end
      tick();
      done = 1'b0;
      check("idle", 64'({busy, grant, ack0, ack1, err0, err1, spi_enable}), 64'(0));
      check("idle_rx", 64'({rx0, rx1}), 64'({mrx[0], mrx[1]}));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, d;
      bit e, il;
      logic [DW-1:0] rd;

      tbl[0] = '{1, 0, 8'd2, 8'd0, 16'hC103, 16'h0000, 5, 16'h0508, 0, 0, 0};
      tbl[1] = '{1, 1, 8'd1, 8'd2, 16'h1111, 16'h2222, 3, 16'hA1A1, 1, 0, 0};
      tbl[2] = '{0, 1, 8'd0, 8'd2, 16'h0000, 16'h3333, 4, 16'hB2B2, 0, 0, 0};
      tbl[3] = '{0, 0, 8'd0, 8'd0, 16'h0000, 16'h0000, 2, 16'hC3C3, 1, 0, 0};
      tbl[4] = '{0, 1, 8'd0, 8'd0, 16'h0000, 16'h9999, 3, 16'hFFFF, 1, 1, 0};
      tbl[5] = '{0, 1, 8'd0, 8'd3, 16'h0000, 16'h8888, 3, 16'hFFFF, 1, 1, 0};
      tbl[6] = '{1, 0, 8'd2, 8'd0, 16'hABCD, 16'h0000, NEVER, 16'hFFFF, 0, 1, 1};
      tbl[7] = '{1, 0, 8'd1, 8'd0, 16'h7777, 16'h0000, T-1, 16'h5A5A, 0, 0, 0};
      tbl[8] = '{1, 0, 8'd2, 8'd0, 16'h4444, 16'h0000, T, 16'h6B6B, 0, 1, 0};
      pend[0] = 0; pend[1] = 0;
      mlen[0] = 0; mlen[1] = 0; mtx[0] = 0; mtx[1] = 0; mrx[0] = 0; mrx[1] = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", 64'({ack0, ack1, err0, err1, busy, spi_enable, grant}), 64'(0));
      check("rst_data", 64'({rx0, rx1, spi_data_in}), 64'(0));
      check("rst_len", 64'(spi_length), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         if (tbl[i].r0) raise(0, tbl[i].l0, tbl[i].t0);
         if (tbl[i].r1) raise(1, tbl[i].l1, tbl[i].t1);
         xfer(tbl[i].w, tbl[i].err, tbl[i].d, tbl[i].rd, 1'b0);
         if (tbl[i].late) begin
            done = 1'b1; dout = 16'hDEAD;
            tick();
            done = 1'b0;
            check("late_done", 64'({busy, ack0, ack1, err0, err1, grant}), 64'(0));
            check("late_rx", 64'({rx0, rx1}), 64'({mrx[0], mrx[1]}));
         end
      end

      // reset in the middle of a WAIT
      raise(0, 8'd2, 16'h1234);
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("rst_mid", 64'({grant, busy, spi_enable, ack0, ack1}), 64'(0));
      check("rst_mid_rx", 64'({rx0, rx1}), 64'(0));
      mrx[0] = 0; mrx[1] = 0; last = 1;
      raise(1, 8'd2, 16'h4321);
      #1;
      rst = 1'b0;

      // contention: both pending, each re-requests right after its ack
      for (int i = 0; i < 6; i++) begin
         xfer(i % 2, 1'b0, 2 + i, 16'hA000 + 16'(i), 1'b0);
         if (i < 4) raise(i % 2, 8'd1 + 8'(i % 2), 16'hB000 + 16'(i));
      end

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 2; i++)
            if (!pend[i] && ($urandom % 2 == 1)) raise(i, 8'($urandom % 4), 16'($urandom));
         if (!pend[0] && !pend[1]) raise(int'($urandom % 2), 8'($urandom % 4), 16'($urandom));
         w = predict_winner();
         il = (mlen[w] == 8'd0) || (int'(mlen[w]) > MAXL);
         case ($urandom % 8)
            0:       d = NEVER;
            1:       d = T - 1;
            default: d = 1 + int'($urandom % 12);
         endcase
         e  = il || (d > T - 1);
         rd = 16'($urandom);
         xfer(w, e, d, rd, bit'($urandom % 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
